usb_data_buffer: RTL
====================

# usb_data_buffer

Single-clock 64-byte byte FIFO between the USB RX/TX protocol blocks and the AHB-Lite slave interface. `usb_rx` writes decoded payload bytes in with `store_rx_packet_data` and monitors `buffer_occupancy`. The AHB slave drains those bytes with `get_rx_data`, and it also fills the buffer with TX payload that `usb_tx` later drains. A single storage array and occupancy count serve both directions; the USB protocol guarantees that only one direction is active at a time.

## Interface
- `DEPTH`, 64: number of byte entries; must be a power of two.
- `DATA_W`, 8: entry width in bits.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `store_rx_packet_data` in 1: write `rx_packet_data` this cycle (from `usb_rx`).
- `rx_packet_data` in 8: RX write data.
- `flush` in 1: empty the buffer (from `usb_rx`, at start of a new data packet).
- `store_tx_data` in 1: write `tx_data` this cycle (from AHB slave).
- `tx_data` in 8: TX write data.
- `get_rx_data` in 1: pop one byte to `rx_data` (from AHB slave).
- `get_tx_packet_data` in 1: pop one byte to `tx_packet_data` (from `usb_tx`).
- `clear` in 1: empty the buffer (from AHB slave, software-initiated).
- `rx_data` out 8: registered RX read data.
- `tx_packet_data` out 8: registered TX read data.
- `buffer_occupancy` out 7: byte count, 0..64.

## Operation
- State consists of:
  - `mem[0:63]` × 8 storage array.
  - 6-bit `wr_ptr` and `rd_ptr`; both wrap 63→0 by natural overflow.
  - 7-bit `count`; `buffer_occupancy = count`.
- Reset values: pointers 0, `count` 0, `rx_data` 8'h00, `tx_packet_data` 8'h00. `mem` is not reset.
- Write request:
  - `wr_req = store_rx_packet_data | store_tx_data`.
  - If both strobes are high, the RX byte is written and the TX byte is discarded.
- Read request:
  - `rd_req = get_rx_data | get_tx_packet_data`.
  - If both strobes are high, only the RX read port is serviced.
- Accepted write: `wr_req & (count < 64 | rd_ok)` writes `mem[wr_ptr]` and increments `wr_ptr`.
- Accepted read: `rd_ok = rd_req & (count != 0)` loads the selected output register with `mem[rd_ptr]` and increments `rd_ptr`. The other output register holds its value.
- `count` update: `+1` for write only, `-1` for read only, unchanged when both or neither are accepted.
- Full (count = 64):
  - Write alone is dropped; no pointer or count change.
  - Simultaneous write and read are both accepted; `count` stays 64.
- Empty (count = 0):
  - Read is ignored and the output register holds its value.
  - Simultaneous write and read: only the write is accepted, `count` becomes 1, and the read is not serviced that cycle.
- `flush | clear` has highest priority: pointers and `count` go to 0 at the edge. Any write or read strobe in the same cycle is ignored. Output data registers hold their values.
- Reset asserted mid-transfer immediately returns the block to reset values; stored bytes become unreachable.

## Timing
- Write-to-occupancy latency is 1 cycle: `buffer_occupancy` reflects a write after the same rising edge that captures it.
- Read latency is 1 cycle: `rx_data`/`tx_packet_data` are valid in the cycle after the `get_*` strobe and hold until the next accepted read on that port.
- A byte written at edge N can be read by a strobe sampled at edge N+1; no same-edge write-through.
- Throughput: one write and one read per cycle sustained.
- Strobes are level-sampled per cycle. A strobe held for k cycles performs k operations, subject to the full/empty rules.
- `buffer_occupancy` is a register output with no combinational path from any input.

## Structure
- Shared package `usb_pkg`:
  - `BUF_DEPTH = 64`, `BUF_AW = 6`, `BYTE_W = 8`.
  - `typedef logic [BUF_AW:0] occ_t` for occupancy.
- These constants are reused by `usb_rx` (full check) and the AHB slave (status register).
- One sub-module, `buf_ptr`: 6-bit wrapping pointer with synchronous clear and increment enable, instantiated twice.
- The array, count, arbitration and output registers stay in `usb_data_buffer`.

## Test plan
- Reset:
  - Stimulus: assert `rst` mid-cycle with arbitrary strobes.
  - Response: immediately `buffer_occupancy = 0`, `rx_data = 8'h00`, `tx_packet_data = 8'h00`. After release, `get_rx_data` pulses leave all outputs unchanged.
- RX path:
  - Stimulus: store 8'hA5, 8'h3C, 8'hFF on consecutive cycles, then 3 `get_rx_data` pulses.
  - Response: occupancy 1, 2, 3, then 2, 1, 0. `rx_data` is A5, 3C, FF, each one cycle after its strobe.
- Full boundary:
  - Stimulus: store 0..63, then store 8'h77.
  - Response: occupancy stays 64 and 8'h77 is dropped.
  - Then: store 8'h88 with `get_rx_data` in the same cycle. Response: `rx_data = 8'h00` and occupancy stays 64. Draining 64 bytes then yields 1..63, 8'h88.
- Wrap-around:
  - Stimulus: 100 cycles of simultaneous store and `get_rx_data` of an incrementing pattern, starting from occupancy 5.
  - Response: occupancy constant at 5; the read sequence equals the written sequence delayed by 5.
- Empty and simultaneous events:
  - Stimulus: `get_tx_packet_data` at occupancy 0 → `tx_packet_data` held and occupancy stays 0.
  - Stimulus: store 8'h11 together with a read at occupancy 0 → occupancy 1. The next read returns 8'h11.
- Flush and clear priority:
  - Stimulus: at occupancy 10, assert `flush` together with `store_rx_packet_data` → occupancy 0 next cycle.
  - Stimulus: repeat with `clear` and `get_rx_data` → occupancy 0 and `rx_data` unchanged.
  - Follow-up: a store after either case lands at entry 0 and reads back correctly.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared constants and types for the USB data path (buffer, usb_rx, AHB slave).
package usb_pkg;

    localparam int unsigned BUF_DEPTH = 64;
    localparam int unsigned BUF_AW    = 6;
    localparam int unsigned BYTE_W    = 8;

    typedef logic [BUF_AW:0] occ_t;

endpackage : usb_pkg

// File: rtl/buf_ptr.sv
// Wrapping FIFO pointer with synchronous clear and increment enable.
module buf_ptr #(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // Wrap relies on natural overflow of the AW-bit register.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : buf_ptr

// File: rtl/usb_data_buffer.sv
// Shared single-clock byte FIFO between USB RX/TX protocol blocks and the AHB slave.
// One direction is active at a time; RX strobes win when both ports request.
module usb_data_buffer
    import usb_pkg::*;
#(
    parameter int unsigned DEPTH  = BUF_DEPTH,
    parameter int unsigned DATA_W = BYTE_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       store_rx_packet_data,
    input  logic [DATA_W-1:0]          rx_packet_data,
    input  logic                       flush,
    input  logic                       store_tx_data,
    input  logic [DATA_W-1:0]          tx_data,
    input  logic                       get_rx_data,
    input  logic                       get_tx_packet_data,
    input  logic                       clear,
    output logic [DATA_W-1:0]          rx_data,
    output logic [DATA_W-1:0]          tx_packet_data,
    output logic [$clog2(DEPTH):0]     buffer_occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    typedef logic [AW:0] cnt_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    cnt_t              count_q, count_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              clr, wr_req, rd_req, wr_ok, rd_ok;
    logic [DATA_W-1:0] wr_data;

    // Flush/clear override every strobe in the same cycle.
    assign clr     = flush | clear;
    assign wr_req  = store_rx_packet_data | store_tx_data;
    assign rd_req  = get_rx_data | get_tx_packet_data;
    assign rd_ok   = rd_req & (count_q != '0) & ~clr;
    assign wr_ok   = wr_req & ((count_q < cnt_t'(DEPTH)) | rd_ok) & ~clr;
    assign wr_data = store_rx_packet_data ? rx_packet_data : tx_data;

    buf_ptr #(.AW(AW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .inc_i (wr_ok),
        .ptr_o (wr_ptr)
    );

    buf_ptr #(.AW(AW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .inc_i (rd_ok),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d   = count_q;
        rx_data_d = rx_data_q;
        tx_data_d = tx_data_q;
        if (clr) begin
            count_d = '0;
        end else begin
            if (wr_ok && !rd_ok) begin
                count_d = count_q + cnt_t'(1);
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - cnt_t'(1);
            end
            if (rd_ok) begin
                if (get_rx_data) begin
                    rx_data_d = mem_q[rd_ptr];
                end else begin
                    tx_data_d = mem_q[rd_ptr];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            rx_data_q <= '0;
            tx_data_q <= '0;
        end else begin
            count_q   <= count_d;
            rx_data_q <= rx_data_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Storage is deliberately not reset; occupancy gates what is reachable.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    assign rx_data          = rx_data_q;
    assign tx_packet_data   = tx_data_q;
    assign buffer_occupancy = count_q;

endmodule : usb_data_buffer
